// File: rtl/lector_transiciones.sv
// Sweeps a bank of transition counters, reading each one and handing it to a
// consumer via valid/ready. Define BORRAR_TRAS_LECTURA_EN to zero each counter after it is read.
module lector_transiciones #(
  parameter int unsigned NUM_CNTR = 3,
  parameter int unsigned NDIR     = 2
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            inicio,
  output logic [NDIR-1:0] dir,
  output logic            LE,
  inout  wire  [31:0]     dato,
  output logic [31:0]     cntr_dato,
  output logic [NDIR-1:0] cntr_dir,
  output logic            cntr_valido,
  input  logic            cntr_listo,
  output logic            ocupado,
  output logic            fin
);

  localparam logic [2:0] REPOSO   = 3'd0;
  localparam logic [2:0] PREPARA  = 3'd1;
  localparam logic [2:0] CAPTURA  = 3'd2;
`ifdef BORRAR_TRAS_LECTURA_EN
  localparam logic [2:0] BORRA    = 3'd3;
`endif
  localparam logic [2:0] PRESENTA = 3'd4;
  localparam logic [2:0] FIN      = 3'd5;

  localparam logic [NDIR-1:0] K_ULTIMO = NDIR'(NUM_CNTR - 1);

  logic [2:0]      estado, estado_d;
  logic [NDIR-1:0] k, k_d;
  logic [31:0]     cap_dato_d;
  logic [NDIR-1:0] cap_dir_d;

  // The sweep index is itself the memory address, so dir is a registered value.
  assign dir = k;

  // Next state, next index and capture values.
  always_comb begin
    estado_d   = estado;
    k_d        = k;
    cap_dato_d = cntr_dato;
    cap_dir_d  = cntr_dir;
    case (estado)
      REPOSO: begin
        if (inicio) begin
          estado_d = PREPARA;
          k_d      = '0;
        end
      end
      PREPARA: estado_d = CAPTURA;
      CAPTURA: begin
        cap_dato_d = dato;
        cap_dir_d  = k;
`ifdef BORRAR_TRAS_LECTURA_EN
        estado_d   = BORRA;
`else
        estado_d   = PRESENTA;
`endif
      end
`ifdef BORRAR_TRAS_LECTURA_EN
      BORRA: estado_d = PRESENTA;
`endif
      PRESENTA: begin
        if (cntr_listo) begin
          if (k == K_ULTIMO) begin
            estado_d = FIN;
          end else begin
            k_d      = k + NDIR'(1);
            estado_d = PREPARA;
          end
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      estado      <= REPOSO;
      k           <= '0;
      cntr_dato   <= '0;
      cntr_dir    <= '0;
      cntr_valido <= 1'b0;
      ocupado     <= 1'b0;
      fin         <= 1'b0;
    end else begin
      estado      <= estado_d;
      k           <= k_d;
      cntr_dato   <= cap_dato_d;
      cntr_dir    <= cap_dir_d;
      cntr_valido <= (estado_d == PRESENTA);
      ocupado     <= (estado_d != REPOSO);
      fin         <= (estado_d == FIN);
    end
  end

`ifdef BORRAR_TRAS_LECTURA_EN
  logic le_q;

  // Memory write enable is low only during the clear cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) le_q <= 1'b1;
    else          le_q <= (estado_d != BORRA);
  end

  assign LE   = le_q;
  assign dato = le_q ? 32'bz : 32'd0;
`else
  assign LE = 1'b1;
`endif

endmodule

// File: tb/tb_lector_transiciones.sv
// Bench for lector_transiciones: 3-counter and 1-counter instances on small
// behavioural memories, with a transfer scoreboard.
module tb_lector_transiciones;

  typedef struct packed {
    logic [1:0]  d;
    logic [31:0] v;
  } exp_t;

`ifdef BORRAR_TRAS_LECTURA_EN
  localparam int SLOT = 4;
  localparam bit BORRA_EN = 1'b1;
`else
  localparam int SLOT = 3;
  localparam bit BORRA_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_L, cargar;
  logic inicio_a, listo_a, inicio_b, listo_b;
  logic [1:0] dir_a, cdir_a;
  logic [0:0] dir_b, cdir_b;
  logic le_a, le_b, valido_a, valido_b, ocupado_a, ocupado_b, fin_a, fin_b;
  logic [31:0] cdato_a, cdato_b;
  wire  [31:0] dato_a, dato_b;
  logic [31:0] mem_a [4];
  logic [31:0] mem_b [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nfin_a = 0;
  int nfin_b = 0;
  logic [1:0] maxd_a = '0;
  logic [0:0] maxd_b = '0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int t_a[$];

  always #5 clk = ~clk;

  lector_transiciones #(.NUM_CNTR(3), .NDIR(2)) dut_a (
    .clk(clk), .reset_L(reset_L), .inicio(inicio_a), .dir(dir_a), .LE(le_a),
    .dato(dato_a), .cntr_dato(cdato_a), .cntr_dir(cdir_a), .cntr_valido(valido_a),
    .cntr_listo(listo_a), .ocupado(ocupado_a), .fin(fin_a)
  );

  lector_transiciones #(.NUM_CNTR(1), .NDIR(1)) dut_b (
    .clk(clk), .reset_L(reset_L), .inicio(inicio_b), .dir(dir_b), .LE(le_b),
    .dato(dato_b), .cntr_dato(cdato_b), .cntr_dir(cdir_b), .cntr_valido(valido_b),
    .cntr_listo(listo_b), .ocupado(ocupado_b), .fin(fin_b)
  );

  // Counter memories: read while LE=1, write on the clock edge while LE=0.
  assign dato_a = le_a ? mem_a[dir_a] : 32'bz;
  assign dato_b = le_b ? mem_b[dir_b] : 32'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cargar) begin
      mem_a[0] <= 32'd5;
      mem_a[1] <= 32'd17;
      mem_a[2] <= 32'd42;
      mem_a[3] <= 32'd0;
      mem_b[0] <= 32'hFFFF_FFFF;
      mem_b[1] <= 32'd0;
    end else begin
      if (!le_a) mem_a[dir_a] <= dato_a;
      if (!le_b) mem_b[dir_b] <= dato_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [1:0] d, input logic [31:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    sb_a.push_back(e);
  endtask

  function automatic logic [31:0] tras_borrado(input logic [31:0] v);
    return BORRA_EN ? 32'd0 : v;
  endfunction

  // Transfers complete on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (reset_L && valido_a && listo_a) begin
      t_a.push_back(cyc);
      if (sb_a.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL xfer_a_extra: observed dir %0h dato %0h expected no transfer", cdir_a, cdato_a);
      end else begin
        e = sb_a.pop_front();
        chk("xfer_a_dir", 64'(cdir_a), 64'(e.d));
        chk("xfer_a_dato", 64'(cdato_a), 64'(e.v));
      end
    end
    if (reset_L && valido_b && listo_b) begin
      if (sb_b.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL xfer_b_extra: observed dato %0h expected no transfer", cdato_b);
      end else begin
        e = sb_b.pop_front();
        chk("xfer_b_dir", 64'(cdir_b), 64'(e.d));
        chk("xfer_b_dato", 64'(cdato_b), 64'(e.v));
      end
    end
    if (fin_a) nfin_a++;
    if (fin_b) nfin_b++;
    if (ocupado_a && dir_a > maxd_a) maxd_a = dir_a;
    if (ocupado_b && dir_b > maxd_b) maxd_b = dir_b;
  end

  task automatic espera_fin_a(input string tag);
    int n = 0;
    while (!fin_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(fin_a), 64'd1);
  endtask

  task automatic espera_valido_a(input string tag);
    int n = 0;
    while (!valido_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(valido_a), 64'd1);
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    reset_L = 1'b0; cargar = 1'b1;
    inicio_a = 1'b0; listo_a = 1'b1; inicio_b = 1'b0; listo_b = 1'b1;
    ciclos(3);
    @(negedge clk);
    chk("rst_dir", 64'(dir_a), 64'd0);
    chk("rst_le", 64'(le_a), 64'd1);
    chk("rst_valido", 64'(valido_a), 64'd0);
    chk("rst_ocupado", 64'(ocupado_a), 64'd0);
    chk("rst_fin", 64'(fin_a), 64'd0);
    chk("rst_cdato", 64'(cdato_a), 64'd0);
    chk("rst_cdir", 64'(cdir_a), 64'd0);
    cargar = 1'b0;
    ciclos(1);
    reset_L = 1'b1;
    ciclos(2);

    // Full sweep with the consumer always ready; checks first-entry latency and slot length.
    push_a(2'd0, 32'd5); push_a(2'd1, 32'd17); push_a(2'd2, 32'd42);
    t_a.delete();
    f0 = nfin_a;
    inicio_a = 1'b1;
    ciclos(1);
    inicio_a = 1'b0;
    for (int i = 1; i <= SLOT; i++) begin
      @(negedge clk);
      chk($sformatf("lat_valido_%0d", i), 64'(valido_a), (i == SLOT) ? 64'd1 : 64'd0);
    end
    espera_fin_a("s1_fin");
    chk("s1_ocupado_en_fin", 64'(ocupado_a), 64'd1);
    @(negedge clk);
    chk("s1_fin_pulso", 64'(fin_a), 64'd0);
    chk("s1_ocupado_cae", 64'(ocupado_a), 64'd0);
    chk("s1_nfin", 64'(nfin_a - f0), 64'd1);
    chk("s1_n_xfer", 64'(t_a.size()), 64'd3);
    if (t_a.size() == 3) begin
      chk("s1_slot01", 64'(t_a[1] - t_a[0]), 64'(SLOT));
      chk("s1_slot12", 64'(t_a[2] - t_a[1]), 64'(SLOT));
    end
    chk("s1_sb_vacio", 64'(sb_a.size()), 64'd0);

    // Second sweep, with an ignored inicio pulse while entry 0 is in flight.
    push_a(2'd0, tras_borrado(32'd5));
    push_a(2'd1, tras_borrado(32'd17));
    push_a(2'd2, tras_borrado(32'd42));
    t_a.delete();
    f0 = nfin_a;
    ciclos(1);
    inicio_a = 1'b1;
    ciclos(1);
    inicio_a = 1'b0;
    ciclos(1);
    inicio_a = 1'b1;
    ciclos(1);
    inicio_a = 1'b0;
    espera_fin_a("s2_fin");
    ciclos(8);
    chk("s2_nfin", 64'(nfin_a - f0), 64'd1);
    chk("s2_n_xfer", 64'(t_a.size()), 64'd3);
    chk("s2_reposo", 64'(ocupado_a), 64'd0);
    chk("s2_sb_vacio", 64'(sb_a.size()), 64'd0);

    // Backpressure on entry 1 with freshly loaded memory.
    cargar = 1'b1;
    ciclos(1);
    cargar = 1'b0;
    push_a(2'd0, 32'd5); push_a(2'd1, 32'd17); push_a(2'd2, 32'd42);
    listo_a = 1'b0;
    inicio_a = 1'b1;
    ciclos(1);
    inicio_a = 1'b0;
    espera_valido_a("bp_valido0");
    listo_a = 1'b1;
    ciclos(1);
    listo_a = 1'b0;
    espera_valido_a("bp_valido1");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valido", 64'(valido_a), 64'd1);
      chk("bp_cdato", 64'(cdato_a), 64'd17);
      chk("bp_cdir", 64'(cdir_a), 64'd1);
    end
    listo_a = 1'b1;
    espera_fin_a("bp_fin");
    ciclos(1);
    chk("bp_sb_vacio", 64'(sb_a.size()), 64'd0);

    // Reset while entry 1 is presented; the sweep must not resume.
    cargar = 1'b1;
    ciclos(1);
    cargar = 1'b0;
    push_a(2'd0, 32'd5);
    listo_a = 1'b0;
    inicio_a = 1'b1;
    ciclos(1);
    inicio_a = 1'b0;
    espera_valido_a("mr_valido0");
    listo_a = 1'b1;
    ciclos(1);
    listo_a = 1'b0;
    espera_valido_a("mr_valido1");
    #2 reset_L = 1'b0;
    #1;
    chk("mr_dir", 64'(dir_a), 64'd0);
    chk("mr_le", 64'(le_a), 64'd1);
    chk("mr_cdato", 64'(cdato_a), 64'd0);
    chk("mr_cdir", 64'(cdir_a), 64'd0);
    chk("mr_valido", 64'(valido_a), 64'd0);
    chk("mr_ocupado", 64'(ocupado_a), 64'd0);
    chk("mr_fin", 64'(fin_a), 64'd0);
    ciclos(2);
    reset_L = 1'b1;
    listo_a = 1'b1;
    ciclos(6);
    chk("mr_no_reanuda", 64'(ocupado_a), 64'd0);
    chk("mr_mem0", 64'(mem_a[0]), 64'(tras_borrado(32'd5)));
    chk("mr_mem1", 64'(mem_a[1]), 64'(tras_borrado(32'd17)));
    chk("mr_mem2", 64'(mem_a[2]), 64'd42);
    chk("mr_sb_vacio", 64'(sb_a.size()), 64'd0);

    // Single-counter instance: one transfer, then fin.
    begin
      exp_t e;
      int n = 0;
      e.d = 2'd0;
      e.v = 32'hFFFF_FFFF;
      sb_b.push_back(e);
      f0 = nfin_b;
      inicio_b = 1'b1;
      ciclos(1);
      inicio_b = 1'b0;
      while (!fin_b && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b_fin", 64'(fin_b), 64'd1);
      ciclos(4);
      chk("b_nfin", 64'(nfin_b - f0), 64'd1);
      chk("b_sb_vacio", 64'(sb_b.size()), 64'd0);
      chk("b_reposo", 64'(ocupado_b), 64'd0);
    end

    chk("max_dir_a", 64'(maxd_a), 64'd2);
    chk("max_dir_b", 64'(maxd_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lector_transiciones.md
LECTOR_TRANSICIONES -- requirements
Module: lector_transiciones

Interface
REQ-001 SHALL have parameter NUM_CNTR, default 3, the number of transition counters to read (1..2^NDIR).
REQ-002 SHALL have parameter NDIR, default 2, the counter address width in bits.
REQ-003 SHALL have port clk  input  1  as its single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_L  input  1  as the reset, asynchronous and active-low.
REQ-005 SHALL have port inicio  input  1  to start a read sweep, sampled only in REPOSO.
REQ-006 SHALL have port dir  output  NDIR  as the counter-memory address.
REQ-007 SHALL have port LE  output  1  as the counter-memory control: 1 = read, 0 = write.
REQ-008 SHALL have port dato  inout  32  as the counter-memory data bus, driven only while LE=0.
REQ-009 SHALL have port cntr_dato  output  32  carrying the captured counter value.
REQ-010 SHALL have port cntr_dir  output  NDIR  carrying the address of cntr_dato.
REQ-011 SHALL have port cntr_valido  output  1  flagging that cntr_dato/cntr_dir hold a value.
REQ-012 SHALL have port cntr_listo  input  1  as the consumer's ready signal.
REQ-013 SHALL have port ocupado  output  1, high in any state other than REPOSO.
REQ-014 SHALL have port fin  output  1, a one-cycle pulse at the end of a sweep.

Function
REQ-015 SHALL implement states REPOSO, PREPARA, CAPTURA, BORRA (macro only), PRESENTA and FIN.
REQ-016 SHALL go REPOSO->PREPARA on inicio=1, loading index k=0; otherwise stay in REPOSO.
REQ-017 SHALL, in PREPARA, drive dir=k and LE=1 for one cycle so the data settles, then go to CAPTURA.
REQ-018 SHALL, in CAPTURA, register dato into cntr_dato and k into cntr_dir at the cycle end, then go to BORRA if enabled, else PRESENTA.
REQ-019 SHALL hold cntr_valido=1 and outputs stable in PRESENTA until a rising edge with cntr_listo=1, which completes the transfer.
REQ-020 SHALL, on transfer, go to FIN if k=NUM_CNTR-1, else increment k and go to PREPARA.
REQ-021 SHALL drive fin=1 for exactly one cycle in FIN, then return to REPOSO.
REQ-022 SHALL make cntr_valido high 3 cycles after the edge sampling inicio, or 4 with BORRA; with cntr_listo held at 1 each entry SHALL take 3 (4) cycles.
REQ-023 SHALL ignore inicio while ocupado=1; inicio held high in FIN/REPOSO starts a new sweep from the next REPOSO cycle.
REQ-024 SHALL never present dir above NUM_CNTR-1, with no wrap; NUM_CNTR=1 yields one transfer then FIN.
REQ-025 SHALL keep LE=1 and dato=32'bz in every state except BORRA, so the memory is never written unintentionally.
REQ-026 SHALL drop cntr_valido to 0 the cycle after the transfer.

Reset
REQ-027 SHALL, on reset_L=0 at any time including mid-sweep, immediately enter REPOSO with k=0, dir=0, LE=1, dato=z, cntr_dato=0, cntr_dir=0, cntr_valido=0, ocupado=0 and fin=0.
REQ-028 SHALL leave memory contents untouched by reset, and a sweep aborted by reset SHALL not resume.

Configuration
REQ-029 SHALL use macro BORRAR_TRAS_LECTURA_EN to select clear-after-read.
REQ-030 SHALL, with BORRAR_TRAS_LECTURA_EN defined, spend one BORRA cycle after CAPTURA driving dir=k, LE=0 and dato=0, zeroing the counter, then go to PRESENTA.
REQ-031 SHALL, without BORRAR_TRAS_LECTURA_EN, have no BORRA state, never drive dato, and hold LE at 1 constantly.

Verification
REQ-032 SHALL verify a full sweep: memory {5, 17, 42}, cntr_listo=1, pulse inicio -> transfers (0,5), (1,17), (2,42) on consecutive 3-cycle slots, fin pulses once, and ocupado falls with fin.
REQ-033 SHALL verify backpressure: cntr_listo=0 for 10 cycles on entry 1 -> cntr_valido held, cntr_dato=17 stable, and no advance until cntr_listo=1.
REQ-034 SHALL verify clear-after-read: with BORRAR_TRAS_LECTURA_EN and memory {5,17,42}, a sweep yields 5,17,42 and a second sweep yields 0,0,0; without the macro the second sweep again yields 5,17,42.
REQ-035 SHALL verify reset mid-sweep: reset_L=0 during PRESENTA of entry 1 -> all outputs at reset values at once, LE=1, and memory unchanged at {5,17,42}.
REQ-036 SHALL verify inicio in a busy sweep: inicio pulsed during entry 0 -> exactly 3 transfers and one fin.
REQ-037 SHALL verify the boundary: NUM_CNTR=1, memory {32'hFFFFFFFF} -> one transfer (0, FFFFFFFF) followed by fin.
